// File: rtl/eth_ipv4_udp_dst_arbiter.sv
// Packet-level round-robin arbiter feeding one UDP framer, latching each winner's destination MAC/IP/UDP at grant.
// Optional per-port packet counters are enabled with `define ETH_UDP_ARB_PKT_CNT_EN.
module eth_ipv4_udp_dst_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_W      = 16,
    localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_PORTS*LEN_W-1:0]      s_tuser,
    input  logic [NUM_PORTS-1:0]            s_tlast,
    input  logic [NUM_PORTS-1:0]            s_tvalid,
    output logic [NUM_PORTS-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]           o_tdata,
    output logic [LEN_W-1:0]                o_tuser,
    output logic                            o_tlast,
    output logic                            o_tvalid,
    input  logic                            o_tready,
    output logic [47:0]                     mac_dst,
    output logic [31:0]                     ip_dst,
    output logic [15:0]                     udp_dst,
    output logic [PW-1:0]                   o_port,
    input  logic                            cfg_wr,
    input  logic [PW-1:0]                   cfg_port,
    input  logic [1:0]                      cfg_field,
    input  logic [47:0]                     cfg_data,
    output logic                            busy
`ifdef ETH_UDP_ARB_PKT_CNT_EN
    ,
    input  logic [PW-1:0]                   cnt_sel,
    output logic [31:0]                     cnt_val
`endif
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [PW-1:0]           r_grant, r_last;
    logic [47:0]             r_mac_dst;
    logic [31:0]             r_ip_dst;
    logic [15:0]             r_udp_dst;
    logic [47:0]             r_mac [NUM_PORTS];
    logic [31:0]             r_ip  [NUM_PORTS];
    logic [15:0]             r_udp [NUM_PORTS];
    logic [NUM_PORTS-1:0]    r_en;
    logic [NUM_PORTS-1:0]    w_req;
    logic [PW-1:0]           w_win;
    logic                    w_eop;
    logic [DATA_WIDTH-1:0]   w_tdata [NUM_PORTS];
    logic [LEN_W-1:0]        w_tuser [NUM_PORTS];

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_view
        assign w_tdata[k] = s_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_tuser[k] = s_tuser[k*LEN_W +: LEN_W];
    end

    // First requester strictly after 'last', wrapping; iterate far-to-near so the nearest wins.
    function automatic logic [PW-1:0] f_pick(input logic [NUM_PORTS-1:0] req, input logic [PW-1:0] last);
        logic [PW-1:0] win;
        int            idx;
        win = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_PORTS;
            if (req[idx]) win = PW'(idx);
        end
        return win;
    endfunction

    assign w_req = s_tvalid & r_en;
    assign w_win = f_pick(w_req, r_last);
    assign w_eop = (r_state == PKT) & o_tvalid & o_tready & o_tlast;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_state_nxt = PKT;
            PKT:     if (w_eop)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_tready = '0;
        o_tvalid = 1'b0;
        o_tlast  = 1'b0;
        o_tdata  = '0;
        o_tuser  = '0;
        busy     = 1'b0;
        if (r_state == PKT) begin
            busy              = 1'b1;
            o_tvalid          = s_tvalid[r_grant];
            o_tlast           = s_tlast[r_grant];
            o_tdata           = w_tdata[r_grant];
            o_tuser           = w_tuser[r_grant];
            s_tready[r_grant] = o_tready;
        end
    end

    // Grant-time snapshot: a config write landing on the same edge is seen only by the next packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant   <= '0;
            r_last    <= PW'(NUM_PORTS - 1);
            r_mac_dst <= '0;
            r_ip_dst  <= '0;
            r_udp_dst <= '0;
        end else if (r_state == IDLE && |w_req) begin
            r_grant   <= w_win;
            r_mac_dst <= r_mac[w_win];
            r_ip_dst  <= r_ip[w_win];
            r_udp_dst <= r_udp[w_win];
        end else if (w_eop) begin
            r_last    <= r_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en <= '1;
            for (int k = 0; k < NUM_PORTS; k++) begin
                r_mac[k] <= '0;
                r_ip[k]  <= '0;
                r_udp[k] <= '0;
            end
        end else if (cfg_wr) begin
            case (cfg_field)
                2'd0: r_mac[cfg_port] <= cfg_data;
                2'd1: r_ip[cfg_port]  <= cfg_data[31:0];
                2'd2: r_udp[cfg_port] <= cfg_data[15:0];
                default: r_en[cfg_port] <= cfg_data[0];
            endcase
        end
    end

    assign mac_dst = r_mac_dst;
    assign ip_dst  = r_ip_dst;
    assign udp_dst = r_udp_dst;
    assign o_port  = r_grant;

`ifdef ETH_UDP_ARB_PKT_CNT_EN
    logic [31:0] r_cnt [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PORTS; k++) r_cnt[k] <= '0;
            cnt_val <= '0;
        end else begin
            if (w_eop) r_cnt[r_grant] <= r_cnt[r_grant] + 32'd1;
            cnt_val <= r_cnt[cnt_sel];
        end
    end
`endif

endmodule
